alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one `alu` core between up to NUM_REQ requesters on a single clock domain.
- Each request carries a complete operation: opcode, operands, carry_in and borrow_in.
- For each granted request, the block latches the operation, issues it with a one-cycle `input_ready` strobe, and waits for `result_ready`.
- It then returns the result and flags to the granted requester with a one-cycle done pulse.
- It replaces ad-hoc divided-clock sequencing around the ALU with a proper handshake.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 255, WAIT-state watchdog limit in clk cycles (only used with ALU_ARB_TIMEOUT_EN)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-low (rst==0 on a posedge resets the block)
- req  in  NUM_REQ  per-requester request level; held until matching done
- req_opcode  in  5*NUM_REQ  packed opcodes, requester i at [5i+4:5i]
- req_operand_A  in  8*NUM_REQ  packed operand A
- req_operand_B  in  8*NUM_REQ  packed operand B
- req_carry_in  in  NUM_REQ  per-requester carry_in
- req_borrow_in  in  NUM_REQ  per-requester borrow_in
- gnt  out  NUM_REQ  one-hot grant, held from ISSUE through RESP
- done  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_result  out  8  result, valid while done!=0
- rsp_flags  out  5  {overflow, negative, zero, carry_out, borrow_out}, valid while done!=0
- rsp_err  out  1  timeout indication, valid while done!=0
- busy  out  1  high whenever the state is not IDLE
- alu_opcode, alu_operand_A, alu_operand_B  out  5/8/8  to alu, driven from the latched request
- alu_carry_in, alu_borrow_in, alu_enable, alu_input_ready  out  1 each  to alu
- alu_result_out  in  8;  alu_carry_out, alu_borrow_out, alu_zero, alu_negative, alu_overflow, alu_result_ready  in  1 each  from alu

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If req!=0, select the first set bit scanning upward from ptr+1, wrapping modulo NUM_REQ.
  - Latch that requester's opcode, operands, carry_in and borrow_in into the alu_* registers.
  - Set gnt, then go to ISSUE.
- **ISSUE:** alu_input_ready=1 for exactly this cycle; go to WAIT.
- **WAIT:** alu_result_ready is sampled only in this state. When it is 1:
  - capture alu_result_out and the five flags into the rsp_* registers;
  - set rsp_err=0;
  - go to RESP.
- **RESP:**
  - done[grant]=1 for one cycle.
  - ptr <= grant index.
  - gnt is cleared on exit; go to IDLE.
- **Latched inputs:** requester inputs are sampled only in IDLE at grant. Later changes do not affect the operation in flight.
- **Dropped request:** if req[grant] drops mid-operation, the operation still completes and done still pulses.
- **Re-arbitration:** a requester whose req is still high in the cycle after done is treated as a new request. Round-robin rotation means it loses to any other pending requester.
- **Simultaneous requests:** resolved by the rotating priority; no requester starves (worst-case wait is NUM_REQ-1 operations).
- **alu_enable:** 1 in every state; 0 only during reset.
- **rsp_result/rsp_flags:** hold their last value outside RESP.

## Timing
- **Reset values:**
  - all outputs 0;
  - state IDLE;
  - ptr=NUM_REQ-1, so requester 0 has top priority after reset;
  - watchdog counter 0.
- **Reset mid-operation:** rst==0 in any state returns the FSM to IDLE next cycle. The aborted operation produces no done pulse.
- **Latency** from req seen in IDLE to done: 3 + L cycles, where L ≥ 1 is the number of WAIT cycles up to and including the one with alu_result_ready=1.
- **Minimum occupancy:** 4 cycles per operation. Back-to-back grants have one IDLE cycle between RESP and the next ISSUE.
- **ISSUE-cycle result_ready:** an alu_result_ready pulse during ISSUE is ignored. The ALU must present result_ready at least one cycle after input_ready.

## Configuration
- **ALU_ARB_TIMEOUT_EN defined:**
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without alu_result_ready, go to RESP with rsp_result=0, rsp_flags=0 and rsp_err=1.
  - ptr still advances.
- **ALU_ARB_TIMEOUT_EN undefined:** no counter; WAIT persists until alu_result_ready; rsp_err is tied to 0.

## Test plan
The bench uses an ALU stub: result = operand_A + operand_B, carry_out from bit 8, result_ready 2 cycles after input_ready.
- **Single request:** req=4'b0010, A=8'h0F, B=8'h01 → gnt=4'b0010; one input_ready pulse; done=4'b0010 on cycle 5 after req; rsp_result=8'h10, rsp_flags=5'b00000.
- **Flag check:** A=8'hFF, B=8'h01 → rsp_result=8'h00, zero=1, carry_out=1.
- **Round-robin order:** req=4'b1111 held, with all four requesters re-requesting after each done → grant order 0,1,2,3,0,… and exactly one done per operation.
- **Mid-operation changes:** req[2] dropped and req_operand_A changed during WAIT → done[2] still pulses with the originally latched result.
- **Timeout (ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16):** stub never asserts result_ready → done pulses with rsp_err=1 and rsp_result=0 after 16 WAIT cycles; the next request is served normally.
- **Reset in WAIT:** rst=0 for one cycle while in WAIT → busy=0, gnt=0, no done; a subsequent req=4'b1000 is granted normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one alu core
// between NUM_REQ requesters with an issue/wait/respond handshake.
// Ports: clk, rst (sync, active-low); req, req_opcode,
//   req_operand_A/B, req_carry_in, req_borrow_in from requesters;
//   gnt, done, rsp_result, rsp_flags, rsp_err, busy to requesters;
//   alu_* outputs drive the alu, alu_* inputs return its result.
// Optional: define ALU_ARB_TIMEOUT_EN for the WAIT-state watchdog.
module alu_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [5*NUM_REQ-1:0]   req_opcode,
   input  logic [8*NUM_REQ-1:0]   req_operand_A,
   input  logic [8*NUM_REQ-1:0]   req_operand_B,
   input  logic [NUM_REQ-1:0]     req_carry_in,
   input  logic [NUM_REQ-1:0]     req_borrow_in,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     done,
   output logic [7:0]             rsp_result,
   output logic [4:0]             rsp_flags,
   output logic                   rsp_err,
   output logic                   busy,
   output logic [4:0]             alu_opcode,
   output logic [7:0]             alu_operand_A,
   output logic [7:0]             alu_operand_B,
   output logic                   alu_carry_in,
   output logic                   alu_borrow_in,
   output logic                   alu_enable,
   output logic                   alu_input_ready,
   input  logic [7:0]             alu_result_out,
   input  logic                   alu_carry_out,
   input  logic                   alu_borrow_out,
   input  logic                   alu_zero,
   input  logic                   alu_negative,
   input  logic                   alu_overflow,
   input  logic                   alu_result_ready
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
      $error("alu_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [4:0]         op_q, op_d;
   logic [7:0]         a_q, a_d;
   logic [7:0]         b_q, b_d;
   logic               cin_q, cin_d;
   logic               bin_q, bin_d;
   logic               ird_q, ird_d;
   logic               en_q;
   logic [7:0]         res_q, res_d;
   logic [4:0]         flg_q, flg_d;
`ifdef ALU_ARB_TIMEOUT_EN
   logic               err_q, err_d;
   logic [7:0]         cnt_q, cnt_d;
`endif

   // Rotating-priority pick: scan downward so the lowest offset
   // from ptr+1 that has a request is the one left in sel.
   logic [IW-1:0] sel;
   logic          sel_vld;
   logic [IW-1:0] jj;
   int            j;

   always_comb begin
      sel     = ptr_q;
      sel_vld = 1'b0;
      j       = 0;
      jj      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j  = (int'(ptr_q) + k) % NUM_REQ;
         jj = IW'(j);
         if (req[jj]) begin
            sel     = jj;
            sel_vld = 1'b1;
         end
      end
   end

   // Operation fields of the selected requester.
   logic [4:0] op_sel;
   logic [7:0] a_sel;
   logic [7:0] b_sel;
   logic       cin_sel;
   logic       bin_sel;

   always_comb begin
      op_sel  = '0;
      a_sel   = '0;
      b_sel   = '0;
      cin_sel = 1'b0;
      bin_sel = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == sel) begin
            op_sel  = req_opcode[5*i +: 5];
            a_sel   = req_operand_A[8*i +: 8];
            b_sel   = req_operand_B[8*i +: 8];
            cin_sel = req_carry_in[i];
            bin_sel = req_borrow_in[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      ird_d   = 1'b0;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      bin_d   = bin_q;
      res_d   = res_q;
      flg_d   = flg_q;
`ifdef ALU_ARB_TIMEOUT_EN
      err_d   = err_q;
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (sel_vld) begin
               gidx_d     = sel;
               gnt_d      = '0;
               gnt_d[sel] = 1'b1;
               op_d       = op_sel;
               a_d        = a_sel;
               b_d        = b_sel;
               cin_d      = cin_sel;
               bin_d      = bin_sel;
               ird_d      = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (alu_result_ready) begin
               res_d          = alu_result_out;
               flg_d          = {alu_overflow, alu_negative, alu_zero,
                                 alu_carry_out, alu_borrow_out};
               done_d[gidx_q] = 1'b1;
               state_d        = RESP;
`ifdef ALU_ARB_TIMEOUT_EN
               err_d          = 1'b0;
`endif
            end
`ifdef ALU_ARB_TIMEOUT_EN
            // cnt_q counts completed WAIT cycles; this is the last one.
            else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               res_d          = '0;
               flg_d          = '0;
               err_d          = 1'b1;
               done_d[gidx_q] = 1'b1;
               state_d        = RESP;
            end
            else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         RESP: begin
            ptr_d   = gidx_q;
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NUM_REQ - 1);
         gidx_q  <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         bin_q   <= 1'b0;
         ird_q   <= 1'b0;
         en_q    <= 1'b0;
         res_q   <= '0;
         flg_q   <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         bin_q   <= bin_d;
         ird_q   <= ird_d;
         en_q    <= 1'b1;
         res_q   <= res_d;
         flg_q   <= flg_d;
`ifdef ALU_ARB_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt             = gnt_q;
   assign done            = done_q;
   assign rsp_result      = res_q;
   assign rsp_flags       = flg_q;
`ifdef ALU_ARB_TIMEOUT_EN
   assign rsp_err         = err_q;
`else
   assign rsp_err         = 1'b0;
`endif
   assign busy            = (state_q != IDLE);
   assign alu_opcode      = op_q;
   assign alu_operand_A   = a_q;
   assign alu_operand_B   = b_q;
   assign alu_carry_in    = cin_q;
   assign alu_borrow_in   = bin_q;
   assign alu_enable      = en_q;
   assign alu_input_ready = ird_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter
// with an adder ALU stub and a queue-based round-robin model.
module tb_alu_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [5*N-1:0] req_opcode;
   logic [8*N-1:0] req_operand_A;
   logic [8*N-1:0] req_operand_B;
   logic [N-1:0]   req_carry_in;
   logic [N-1:0]   req_borrow_in;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [7:0]     rsp_result;
   logic [4:0]     rsp_flags;
   logic           rsp_err;
   logic           busy;
   logic [4:0]     alu_opcode;
   logic [7:0]     alu_operand_A;
   logic [7:0]     alu_operand_B;
   logic           alu_carry_in;
   logic           alu_borrow_in;
   logic           alu_enable;
   logic           alu_input_ready;
   logic [7:0]     alu_result_out;
   logic           alu_carry_out;
   logic           alu_borrow_out;
   logic           alu_zero;
   logic           alu_negative;
   logic           alu_overflow;
   logic           alu_result_ready;

   alu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req(req),
      .req_opcode(req_opcode),
      .req_operand_A(req_operand_A),
      .req_operand_B(req_operand_B),
      .req_carry_in(req_carry_in),
      .req_borrow_in(req_borrow_in),
      .gnt(gnt), .done(done),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .rsp_err(rsp_err), .busy(busy),
      .alu_opcode(alu_opcode),
      .alu_operand_A(alu_operand_A),
      .alu_operand_B(alu_operand_B),
      .alu_carry_in(alu_carry_in),
      .alu_borrow_in(alu_borrow_in),
      .alu_enable(alu_enable),
      .alu_input_ready(alu_input_ready),
      .alu_result_out(alu_result_out),
      .alu_carry_out(alu_carry_out),
      .alu_borrow_out(alu_borrow_out),
      .alu_zero(alu_zero),
      .alu_negative(alu_negative),
      .alu_overflow(alu_overflow),
      .alu_result_ready(alu_result_ready)
   );

   always #5 clk = ~clk;

   // ALU stub: adder, result_ready stub_lat cycles after input_ready
   // (stub_lat 0 = never ready).
   int         stub_lat;
   int         st_cnt;
   logic [7:0] st_a, st_b;
   logic [8:0] st_sum;

   always @(posedge clk) begin
      if (!rst) begin
         st_cnt <= 0;
      end else if (alu_input_ready) begin
         st_cnt <= stub_lat;
         st_a   <= alu_operand_A;
         st_b   <= alu_operand_B;
      end else if (st_cnt != 0) begin
         st_cnt <= st_cnt - 1;
      end
   end

   assign st_sum           = {1'b0, st_a} + {1'b0, st_b};
   assign alu_result_out   = st_sum[7:0];
   assign alu_carry_out    = st_sum[8];
   assign alu_zero         = ~|st_sum[7:0];
   assign alu_negative     = st_sum[7];
   assign alu_overflow     = (st_a[7] == st_b[7]) && (st_sum[7] != st_a[7]);
   assign alu_borrow_out   = (st_a < st_b);
   assign alu_result_ready = (st_cnt == 1);

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected {result, ov, neg, zero, carry, borrow} by plain arithmetic.
   function automatic logic [12:0] ref_alu(input logic [7:0] a,
                                            input logic [7:0] b);
      int s, r, sa, sb, ss;
      s  = int'(a) + int'(b);
      r  = s % 256;
      sa = (int'(a) >= 128) ? int'(a) - 256 : int'(a);
      sb = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
      ss = sa + sb;
      return {r[7:0], (ss > 127 || ss < -128), (r >= 128), (r == 0),
              (s > 255), (int'(a) < int'(b))};
   endfunction

   // Priority order queue: head has highest priority.
   int prio[$];

   task automatic model_reset();
      prio = {};
      for (int i = 0; i < N; i++) prio.push_back(i);
   endtask

   function automatic int model_pick(input logic [N-1:0] r);
      foreach (prio[i]) if (r[prio[i]]) return prio[i];
      return -1;
   endfunction

   task automatic model_served(input int g);
      while (prio[0] != g) prio.push_back(prio.pop_front());
      prio.push_back(prio.pop_front());
   endtask

   logic [4:0] t_op[N];
   logic [7:0] t_a[N];
   logic [7:0] t_b[N];
   logic       t_ci[N];
   logic       t_bi[N];

   task automatic randomize_ops(input bit fixed, input logic [7:0] fa,
                                input logic [7:0] fb);
      for (int i = 0; i < N; i++) begin
         t_op[i] = 5'($urandom);
         t_a[i]  = fixed ? fa : 8'($urandom);
         t_b[i]  = fixed ? fb : 8'($urandom);
         t_ci[i] = 1'($urandom);
         t_bi[i] = 1'($urandom);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_opcode[5*i +: 5]    = t_op[i];
         req_operand_A[8*i +: 8] = t_a[i];
         req_operand_B[8*i +: 8] = t_b[i];
         req_carry_in[i]         = t_ci[i];
         req_borrow_in[i]        = t_bi[i];
      end
   endtask

   // One operation from an IDLE negedge to the IDLE negedge after done.
   task automatic run_op(input logic [N-1:0] r, input int lat,
                         input bit mid, input bit fixed,
                         input logic [7:0] fa, input logic [7:0] fb,
                         output int og);
      int          g, cyc, exp_cyc;
      bit          seen;
      logic [4:0]  eop;
      logic [7:0]  ea, eb;
      logic        eci, ebi;
      logic [12:0] ex;
      logic [N-1:0] onehot;
      stub_lat = lat;
      randomize_ops(fixed, fa, fb);
      req = r;
      pack();
      g   = model_pick(r);
      og  = -1;
      eop = t_op[g]; ea = t_a[g]; eb = t_b[g];
      eci = t_ci[g]; ebi = t_bi[g];
      ex  = (lat == 0) ? 13'd0 : ref_alu(ea, eb);
      exp_cyc = (lat == 0) ? 2 + TO : 2 + lat;
      onehot = '0;
      onehot[g] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) if (gnt[i]) og = i;
      check("gnt_issue", gnt, onehot);
      check("input_ready", alu_input_ready, 1'b1);
      check("alu_latched", {alu_opcode, alu_operand_A, alu_operand_B,
                            alu_carry_in, alu_borrow_in},
                           {eop, ea, eb, eci, ebi});
      cyc  = 1;
      seen = 0;
      while (!seen && cyc < 64) begin
         @(negedge clk);
         cyc++;
         if (done != 0) seen = 1;
         else if (mid && cyc == 2) begin
            randomize_ops(0, 8'h00, 8'h00);
            req[g] = 1'b0;
            pack();
         end
      end
      check("done_seen", seen, 1'b1);
      if (seen) begin
         check("done_cycle", cyc, exp_cyc);
         check("done_onehot", done, onehot);
         check("gnt_resp", gnt, onehot);
         check("rsp_result", rsp_result, ex[12:5]);
         check("rsp_flags", rsp_flags, ex[4:0]);
         check("rsp_err", rsp_err, (lat == 0));
         model_served(g);
      end
      @(negedge clk);
      check("idle_after", {done, gnt, busy}, '0);
      check("rsp_hold", rsp_result, ex[12:5]);
   endtask

   int og, dcount;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      req = '0;
      stub_lat = 2;
      randomize_ops(0, 8'h00, 8'h00);
      pack();
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_outs",
            {gnt, done, rsp_result, rsp_flags, rsp_err, busy,
             alu_opcode, alu_operand_A, alu_operand_B, alu_carry_in,
             alu_borrow_in, alu_enable, alu_input_ready}, '0);
      rst = 1'b1;
      @(negedge clk);
      check("enable_on", alu_enable, 1'b1);

      // All four held: rotation 0,1,2,3,0,...
      for (int k = 0; k < 8; k++) begin
         run_op(4'b1111, 2, 0, 0, 8'h00, 8'h00, og);
         check("rr_order", og, k % N);
      end

      run_op(4'b0010, 2, 0, 1, 8'h0F, 8'h01, og);
      check("single_gnt", og, 1);
      run_op(4'b0001, 2, 0, 1, 8'hFF, 8'h01, og);
      check("flags_zc", {rsp_result, rsp_flags}, {8'h00, 5'b00110});
      run_op(4'b0100, 3, 1, 0, 8'h00, 8'h00, og);
      check("mid_gnt", og, 2);

`ifdef ALU_ARB_TIMEOUT_EN
      run_op(4'b0010, 0, 0, 0, 8'h00, 8'h00, og);
      run_op(4'b0010, 2, 0, 0, 8'h00, 8'h00, og);
`endif

      // Reset while in WAIT.
      stub_lat = 3;
      randomize_ops(0, 8'h00, 8'h00);
      req = 4'b0100;
      pack();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      check("rst_wait", {busy, gnt, done, alu_input_ready}, '0);
      rst = 1'b1;
      model_reset();
      dcount = 0;
      repeat (6) begin
         @(negedge clk);
         if (done != 0) dcount++;
      end
      check("rst_nodone", dcount, 0);
      run_op(4'b1000, 2, 0, 0, 8'h00, 8'h00, og);
      check("rst_regnt", og, 3);

      for (int k = 0; k < 40; k++) begin
         run_op(N'($urandom_range(1, (1 << N) - 1)),
                int'($urandom_range(1, 4)), 1'($urandom), 0,
                8'h00, 8'h00, og);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
